// File: rtl/list_writer_pkg.sv
// Shared types and constants for list_writer: state encoding, chain terminator and walk start.
package list_pkg;

  localparam int LIST_DATA_WIDTH = 32;

  localparam logic [LIST_DATA_WIDTH-1:0] LIST_NULL = 32'd0;
  localparam logic [LIST_DATA_WIDTH-1:0] LIST_HEAD = 32'd0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LINK   = 3'd1,
    ST_CLOSE  = 3'd2,
    ST_VERIFY = 3'd3,
    ST_DONE   = 3'd4
  } list_state_e;

endpackage

// File: rtl/list_writer_if.sv
// Node stream handshake plus RAM write/read port of list_writer.
interface list_writer_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  node_valid;
  logic                  node_ready;
  logic [DATA_WIDTH-1:0] node_addr;
  logic                  node_last;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_raddr;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    input  node_valid,
    input  node_addr,
    input  node_last,
    input  mem_rdata,
    output node_ready,
    output mem_we,
    output mem_waddr,
    output mem_wdata,
    output mem_raddr
  );

  modport slave (
    output node_valid,
    output node_addr,
    output node_last,
    output mem_rdata,
    input  node_ready,
    input  mem_we,
    input  mem_waddr,
    input  mem_wdata,
    input  mem_raddr
  );

endinterface

// File: rtl/list_writer_verifier.sv
// list_verifier: walks the finished chain from the head and checks the step count against
// the linked node count. Used by list_writer only when LIST_WRITER_VERIFY_EN is defined.
module list_verifier
  import list_pkg::*;
#(
  parameter int DATA_WIDTH = LIST_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] count,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] raddr,
  output logic                  vdone,
  output logic                  verror
);

  localparam logic [DATA_WIDTH-1:0] NULL_W = DATA_WIDTH'(LIST_NULL);
  localparam logic [DATA_WIDTH-1:0] HEAD_W = DATA_WIDTH'(LIST_HEAD);
  localparam logic [DATA_WIDTH-1:0] ZERO_W = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] ONE_W  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] p_r;
  logic [DATA_WIDTH-1:0] s_r;
  logic [DATA_WIDTH-1:0] rdata_s;
  logic [DATA_WIDTH-1:0] step_s;
  logic [DATA_WIDTH-1:0] expect_s;
  logic                  stop_s;
  logic                  abort_s;

  // Link read for this step; the closing write is still in flight during the first walk
  // cycle, so a write to the address being read is forwarded instead of the stale word.
  always_comb begin
    rdata_s  = rdata;
    step_s   = s_r + ONE_W;
    expect_s = count + ONE_W;
    stop_s   = 1'b0;
    abort_s  = 1'b0;
    vdone    = 1'b0;
    verror   = 1'b0;
    if (wr_en && (wr_addr == p_r)) begin
      rdata_s = wr_data;
    end else begin
      rdata_s = rdata;
    end
    stop_s  = (rdata_s == NULL_W);
    abort_s = !stop_s && (step_s == expect_s);
    if (en) begin
      vdone  = stop_s || abort_s;
      verror = abort_s || (stop_s && (step_s != expect_s));
    end else begin
      vdone  = 1'b0;
      verror = 1'b0;
    end
  end

  // Walk pointer and step counter; parked at the head whenever no walk is in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_r <= HEAD_W;
      s_r <= ZERO_W;
    end else if (en && !vdone) begin
      p_r <= rdata_s;
      s_r <= step_s;
    end else begin
      p_r <= HEAD_W;
      s_r <= ZERO_W;
    end
  end

  assign raddr = p_r;

endmodule

// File: rtl/list_writer.sv
// list_writer: links a stream of node addresses into a zero-terminated chain in RAM.
// The read-back walk of the finished chain is built only when LIST_WRITER_VERIFY_EN is defined.
module list_writer
  import list_pkg::*;
#(
  parameter int DATA_WIDTH = LIST_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  list_writer_if.master         bus,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [DATA_WIDTH-1:0] count
);

  localparam logic [DATA_WIDTH-1:0] NULL_W = DATA_WIDTH'(LIST_NULL);
  localparam logic [DATA_WIDTH-1:0] HEAD_W = DATA_WIDTH'(LIST_HEAD);
  localparam logic [DATA_WIDTH-1:0] ZERO_W = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] ONE_W  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  list_state_e           state_r;
  list_state_e           state_n;
  logic [DATA_WIDTH-1:0] prev_r;
  logic [DATA_WIDTH-1:0] count_r;
  logic [DATA_WIDTH-1:0] waddr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic                  we_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  error_r;
  logic                  ready_s;
  logic                  hs_s;

`ifdef LIST_WRITER_VERIFY_EN
  logic                  verify_en_s;
  logic                  vdone_s;
  logic                  verr_s;

  assign verify_en_s = (state_r == ST_VERIFY);

  list_verifier #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_verifier (
    .clk     (clk),
    .rst     (rst),
    .en      (verify_en_s),
    .count   (count_r),
    .rdata   (bus.mem_rdata),
    .wr_en   (we_r),
    .wr_addr (waddr_r),
    .wr_data (wdata_r),
    .raddr   (bus.mem_raddr),
    .vdone   (vdone_s),
    .verror  (verr_s)
  );
`else
  logic                  rdata_unused_s;

  assign bus.mem_raddr  = ZERO_W;
  assign rdata_unused_s = ^bus.mem_rdata;
`endif

  // Next-state decode; node_ready depends on the state alone.
  always_comb begin
    state_n = state_r;
    ready_s = 1'b0;
    hs_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_LINK;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_LINK: begin
        ready_s = 1'b1;
        hs_s    = bus.node_valid;
        if (bus.node_valid && bus.node_last) begin
          state_n = ST_CLOSE;
        end else begin
          state_n = ST_LINK;
        end
      end
      ST_CLOSE: begin
`ifdef LIST_WRITER_VERIFY_EN
        state_n = ST_VERIFY;
`else
        state_n = ST_DONE;
`endif
      end
`ifdef LIST_WRITER_VERIFY_EN
      ST_VERIFY: begin
        if (vdone_s) begin
          state_n = ST_DONE;
        end else begin
          state_n = ST_VERIFY;
        end
      end
`endif
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State, chain tail, node count, sticky error and the registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      prev_r  <= HEAD_W;
      count_r <= ZERO_W;
      error_r <= 1'b0;
      we_r    <= 1'b0;
      waddr_r <= ZERO_W;
      wdata_r <= ZERO_W;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      busy_r  <= (state_n != ST_IDLE);
      done_r  <= (state_r == ST_DONE);
      we_r    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            prev_r  <= HEAD_W;
            count_r <= ZERO_W;
            error_r <= 1'b0;
          end
        end
        ST_LINK: begin
          // A zero address would terminate the chain early, so it is dropped and flagged.
          if (hs_s) begin
            if (bus.node_addr != NULL_W) begin
              we_r    <= 1'b1;
              waddr_r <= prev_r;
              wdata_r <= bus.node_addr;
              prev_r  <= bus.node_addr;
              count_r <= count_r + ONE_W;
            end else begin
              error_r <= 1'b1;
            end
          end
        end
        ST_CLOSE: begin
          we_r    <= 1'b1;
          waddr_r <= prev_r;
          wdata_r <= NULL_W;
        end
`ifdef LIST_WRITER_VERIFY_EN
        ST_VERIFY: begin
          if (vdone_s && verr_s) begin
            error_r <= 1'b1;
          end
        end
`endif
        default: begin
          we_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.node_ready = ready_s;
  assign bus.mem_we     = we_r;
  assign bus.mem_waddr  = waddr_r;
  assign bus.mem_wdata  = wdata_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign error          = error_r;
  assign count          = count_r;

endmodule
